// File: rtl/cache_wb.sv
// Direct-mapped, write-back, write-allocate data cache for the single-cycle MIPS core.
// A miss runs one main-memory transaction: an optional dirty-victim write-back plus a block fill.
module cache_wb #(
  parameter int INDEX_BITS = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         read,
  input  logic         write,
  input  logic         main_mem_ready,
  input  logic [31:0]  data_address,
  input  logic [31:0]  write_data,
  input  logic [127:0] load_block,
  output logic [31:0]  load_address,
  output logic [31:0]  read_data,
  output logic [127:0] evicted_block,
  output logic [31:0]  evicted_address,
  output logic         evict,
  output logic         load,
  output logic         memoryReady,
  output logic         wait_access
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 28 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, FILL} state_t;

  state_t                state;
  logic [LINES-1:0]      valid_q;
  logic [LINES-1:0]      dirty_q;
  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic [127:0]          data_mem [LINES];
  logic                  seen_low;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   addr_tag;
  logic [1:0]            word_sel;
  logic                  req;
  logic                  hit;
  logic [31:0]           cur_word;
  logic                  unused_addr_bits;

  assign idx              = data_address[3+INDEX_BITS:4];
  assign addr_tag         = data_address[31:4+INDEX_BITS];
  assign word_sel         = data_address[3:2];
  assign unused_addr_bits = ^data_address[1:0];

  // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
  always_comb begin
    req         = read | write;
    hit         = valid_q[idx] && (tag_mem[idx] == addr_tag);
    cur_word    = data_mem[idx][{word_sel, 5'b0} +: 32];
    read_data   = '0;
    memoryReady = 1'b0;
    if (state == IDLE) begin
      memoryReady = !req || hit;
      if (req && hit) read_data = cur_word;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      valid_q         <= '0;
      dirty_q         <= '0;
      seen_low        <= 1'b0;
      load            <= 1'b0;
      evict           <= 1'b0;
      wait_access     <= 1'b0;
      load_address    <= '0;
      evicted_address <= '0;
      evicted_block   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req && hit && write) begin
            dirty_q[idx] <= 1'b1;
          end else if (req && !hit) begin
            load_address <= {data_address[31:4], 4'b0};
            evict        <= valid_q[idx] && dirty_q[idx];
            if (valid_q[idx]) begin
              evicted_address <= {tag_mem[idx], idx, 4'b0};
              evicted_block   <= data_mem[idx];
            end else begin
              evicted_address <= '0;
              evicted_block   <= '0;
            end
            load        <= 1'b1;
            wait_access <= 1'b1;
            seen_low    <= 1'b0;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          wait_access <= 1'b0;
          state       <= BUSY;
        end
        BUSY: begin
          // Completion is a low phase followed by high; a leftover idle-high is not completion.
          if (!main_mem_ready) seen_low <= 1'b1;
          else if (seen_low)   state    <= FILL;
        end
        FILL: begin
          valid_q[idx] <= 1'b1;
          dirty_q[idx] <= 1'b0;
          load         <= 1'b0;
          evict        <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: tag and data arrays are not reset; valid_q guards them, which keeps them plain RAM.
  always_ff @(posedge clk) begin
    if (state == FILL) begin
      data_mem[idx] <= load_block;
      tag_mem[idx]  <= addr_tag;
    end else if (state == IDLE && write && hit) begin
      data_mem[idx][{word_sel, 5'b0} +: 32] <= write_data;
    end
  end

endmodule

// File: tb/tb_cache_wb.sv
// Directed bench for cache_wb: a behavioural 20-cycle main memory plus scenario tasks.
module tb_cache_wb;

  logic         clk = 1'b0;
  logic         reset;
  logic         read, write, main_mem_ready;
  logic [31:0]  data_address, write_data;
  logic [127:0] load_block;
  logic [31:0]  load_address, read_data, evicted_address;
  logic [127:0] evicted_block;
  logic         evict, load, memoryReady, wait_access;

  int vectors = 0;
  int miscompares = 0;

  logic [127:0] mem [bit [27:0]];

  logic         cap_load, cap_evict, cap_wa_after, cap_held, cap_ok;
  logic [31:0]  cap_laddr, cap_eaddr;
  logic [127:0] cap_eblock;
  int           cap_fill_cycles;

  cache_wb #(.INDEX_BITS(4)) dut (
    .clk(clk), .reset(reset), .read(read), .write(write),
    .main_mem_ready(main_mem_ready), .data_address(data_address),
    .write_data(write_data), .load_block(load_block),
    .load_address(load_address), .read_data(read_data),
    .evicted_block(evicted_block), .evicted_address(evicted_address),
    .evict(evict), .load(load), .memoryReady(memoryReady),
    .wait_access(wait_access)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [127:0] blk(input logic [31:0] a);
    logic [31:0] ba;
    ba = {a[31:4], 4'b0};
    if (mem.exists(a[31:4])) return mem[a[31:4]];
    return {32'h3000_0000 | ba, 32'h2000_0000 | ba, 32'h1000_0000 | ba, ba};
  endfunction

  // Memory side of one miss: latch on wait_access, stay idle-high one extra BUSY cycle,
  // go low for 20 cycles, then write back / present the fill block and raise ready.
  task automatic serve_miss();
    int n;
    load_block = '0;
    cap_ok = 1'b0;
    n = 0;
    while (wait_access !== 1'b1 && n < 5) begin tick(); n++; end
    if (wait_access !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL serve_start wait_access=%b never rose", wait_access);
      return;
    end
    cap_load   = load;
    cap_evict  = evict;
    cap_laddr  = load_address;
    cap_eaddr  = evicted_address;
    cap_eblock = evicted_block;
    tick();
    cap_wa_after = wait_access;
    tick();
    main_mem_ready = 1'b0;
    repeat (20) tick();
    cap_held = (load === cap_load) && (evict === cap_evict) &&
               (load_address === cap_laddr) && (evicted_address === cap_eaddr) &&
               (evicted_block === cap_eblock) && (wait_access === 1'b0) &&
               (memoryReady === 1'b0);
    if (cap_evict) mem[cap_eaddr[31:4]] = cap_eblock;
    load_block = blk(cap_laddr);
    main_mem_ready = 1'b1;
    n = 0;
    while (memoryReady !== 1'b1 && n < 10) begin tick(); n++; end
    cap_fill_cycles = n;
    if (memoryReady !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL serve_done memoryReady=%b never rose", memoryReady);
      return;
    end
    cap_ok = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; read = 1'b0; write = 1'b0;
    data_address = '0; write_data = '0;
    main_mem_ready = 1'b1; load_block = '0;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    vectors++;
    if (memoryReady !== 1'b1 || read_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_ready got rdy=%b rd=%h exp rdy=1 rd=0", memoryReady, read_data);
    end
    vectors++;
    if ({load, evict, wait_access} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_ctrl got load/evict/wa=%b exp 000", {load, evict, wait_access});
    end
    vectors++;
    if (load_address !== 32'h0 || evicted_address !== 32'h0 || evicted_block !== 128'h0) begin
      miscompares++;
      $display("FAIL reset_addr got la=%h ea=%h eb=%h exp all 0",
               load_address, evicted_address, evicted_block);
    end
  endtask

  task automatic test_read_miss_fill();
    tick();
    read = 1'b1; data_address = 32'h0000_0040;
    #1;
    vectors++;
    if (memoryReady !== 1'b0) begin
      miscompares++; $display("FAIL rdmiss_stall got=%b exp=0", memoryReady);
    end
    serve_miss();
    if (!cap_ok) return;
    vectors++;
    if ({cap_load, cap_evict} !== 2'b10 || cap_laddr !== 32'h0000_0040) begin
      miscompares++;
      $display("FAIL rdmiss_req got load=%b evict=%b la=%h exp 1 0 00000040",
               cap_load, cap_evict, cap_laddr);
    end
    vectors++;
    if (cap_wa_after !== 1'b0) begin
      miscompares++; $display("FAIL rdmiss_wa_pulse got wa after ISSUE=%b exp=0", cap_wa_after);
    end
    vectors++;
    if (cap_held !== 1'b1) begin
      miscompares++; $display("FAIL rdmiss_held got=%b exp=1", cap_held);
    end
    vectors++;
    if (cap_fill_cycles != 2) begin
      miscompares++; $display("FAIL rdmiss_fill_lat got=%0d exp=2", cap_fill_cycles);
    end
    vectors++;
    if (read_data !== 32'hBBBB_AAAA) begin
      miscompares++; $display("FAIL rdmiss_data got=%h exp=bbbbaaaa", read_data);
    end
    vectors++;
    if ({load, evict} !== 2'b00) begin
      miscompares++; $display("FAIL rdmiss_clear got load/evict=%b exp=00", {load, evict});
    end
  endtask

  task automatic test_read_hit();
    data_address = 32'h0000_0044;
    #1;
    vectors++;
    if (memoryReady !== 1'b1 || read_data !== 32'hDDDD_CCCC) begin
      miscompares++;
      $display("FAIL rdhit got rdy=%b rd=%h exp 1 ddddcccc", memoryReady, read_data);
    end
    tick();
    vectors++;
    if (wait_access !== 1'b0 || memoryReady !== 1'b1) begin
      miscompares++;
      $display("FAIL rdhit_nowait got wa=%b rdy=%b exp 0 1", wait_access, memoryReady);
    end
  endtask

  task automatic test_write_hit();
    write = 1'b1; data_address = 32'h0000_0048; write_data = 32'hCAFE_F00D;
    #1;
    vectors++;
    if (memoryReady !== 1'b1 || read_data !== 32'h2222_1111) begin
      miscompares++;
      $display("FAIL wrhit_prewrite got rdy=%b rd=%h exp 1 22221111", memoryReady, read_data);
    end
    tick();
    write = 1'b0;
    #1;
    vectors++;
    if (read_data !== 32'hCAFE_F00D || wait_access !== 1'b0) begin
      miscompares++;
      $display("FAIL wrhit_readback got rd=%h wa=%b exp cafef00d 0", read_data, wait_access);
    end
  endtask

  task automatic test_evict_dirty();
    data_address = 32'h0000_0440;
    #1;
    vectors++;
    if (memoryReady !== 1'b0) begin
      miscompares++; $display("FAIL evict_stall got=%b exp=0", memoryReady);
    end
    serve_miss();
    if (!cap_ok) return;
    vectors++;
    if ({cap_load, cap_evict} !== 2'b11 || cap_eaddr !== 32'h0000_0040 ||
        cap_laddr !== 32'h0000_0440) begin
      miscompares++;
      $display("FAIL evict_req got load=%b evict=%b ea=%h la=%h exp 1 1 00000040 00000440",
               cap_load, cap_evict, cap_eaddr, cap_laddr);
    end
    vectors++;
    if (cap_eblock !== 128'h4444_3333_CAFE_F00D_DDDD_CCCC_BBBB_AAAA) begin
      miscompares++;
      $display("FAIL evict_block got=%h exp=44443333cafef00dddddccccbbbbaaaa", cap_eblock);
    end
    vectors++;
    if (read_data !== 32'h0000_0440) begin
      miscompares++; $display("FAIL evict_newdata got=%h exp=00000440", read_data);
    end
    tick();
    data_address = 32'h0000_0048;
    serve_miss();
    if (!cap_ok) return;
    vectors++;
    if (cap_evict !== 1'b0 || cap_eaddr !== 32'h0000_0440) begin
      miscompares++;
      $display("FAIL refill_clean got evict=%b ea=%h exp 0 00000440", cap_evict, cap_eaddr);
    end
    vectors++;
    if (read_data !== 32'hCAFE_F00D) begin
      miscompares++; $display("FAIL refill_data got=%h exp=cafef00d", read_data);
    end
    read = 1'b0;
  endtask

  task automatic test_write_miss();
    tick();
    write = 1'b1; data_address = 32'h0000_0080; write_data = 32'h1234_5678;
    #1;
    vectors++;
    if (memoryReady !== 1'b0) begin
      miscompares++; $display("FAIL wrmiss_stall got=%b exp=0", memoryReady);
    end
    serve_miss();
    if (!cap_ok) return;
    vectors++;
    if ({cap_load, cap_evict} !== 2'b10 || cap_laddr !== 32'h0000_0080) begin
      miscompares++;
      $display("FAIL wrmiss_req got load=%b evict=%b la=%h exp 1 0 00000080",
               cap_load, cap_evict, cap_laddr);
    end
    tick();
    write = 1'b0; read = 1'b1;
    #1;
    vectors++;
    if (read_data !== 32'h1234_5678 || memoryReady !== 1'b1) begin
      miscompares++;
      $display("FAIL wrmiss_merge got rd=%h rdy=%b exp 12345678 1", read_data, memoryReady);
    end
    data_address = 32'h0000_0084;
    #1;
    vectors++;
    if (read_data !== 32'h1000_0080) begin
      miscompares++; $display("FAIL wrmiss_fillword got=%h exp=10000080", read_data);
    end
    tick();
    data_address = 32'h0000_0880;
    serve_miss();
    if (!cap_ok) return;
    vectors++;
    if (cap_evict !== 1'b1 || cap_eaddr !== 32'h0000_0080 ||
        cap_eblock[63:0] !== 64'h1000_0080_1234_5678) begin
      miscompares++;
      $display("FAIL wrmiss_dirty got evict=%b ea=%h eb_lo=%h exp 1 00000080 1000008012345678",
               cap_evict, cap_eaddr, cap_eblock[63:0]);
    end
    vectors++;
    if (read_data !== 32'h0000_0880) begin
      miscompares++; $display("FAIL wrmiss_conflict got=%h exp=00000880", read_data);
    end
    read = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    tick();
    read = 1'b1; data_address = 32'h0000_00C0;
    n = 0;
    while (wait_access !== 1'b1 && n < 5) begin tick(); n++; end
    vectors++;
    if (wait_access !== 1'b1) begin
      miscompares++; $display("FAIL rstmid_start wait_access=%b exp=1", wait_access);
    end
    tick();
    main_mem_ready = 1'b0;
    tick();
    reset = 1'b1; read = 1'b0;
    tick();
    vectors++;
    if ({load, evict, wait_access} !== 3'b000 || memoryReady !== 1'b1 ||
        load_address !== 32'h0) begin
      miscompares++;
      $display("FAIL rstmid_ctrl got load/evict/wa=%b rdy=%b la=%h exp 000 1 0",
               {load, evict, wait_access}, memoryReady, load_address);
    end
    reset = 1'b0; main_mem_ready = 1'b1;
    tick();
    read = 1'b1; data_address = 32'h0000_0044;
    #1;
    vectors++;
    if (memoryReady !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_invalid got rdy=%b exp=0", memoryReady);
    end
    serve_miss();
    if (!cap_ok) return;
    vectors++;
    if (cap_evict !== 1'b0 || read_data !== 32'hDDDD_CCCC) begin
      miscompares++;
      $display("FAIL rstmid_refill got evict=%b rd=%h exp 0 ddddcccc", cap_evict, read_data);
    end
    read = 1'b0;
  endtask

  initial begin
    mem[28'h000_0004] = 128'h4444_3333_2222_1111_DDDD_CCCC_BBBB_AAAA;
    test_reset();
    test_read_miss_fill();
    test_read_hit();
    test_write_hit();
    test_evict_dirty();
    test_write_miss();
    test_reset_mid();
    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cache_wb.md
Name: cache_wb

Overview:
- Direct-mapped, write-back, write-allocate data cache between the single-cycle MIPS core's load/store port and the 128-bit-block main memory.
- Serves word reads and writes on hits with no stall.
- On a miss it runs one main-memory transaction: optional dirty-victim eviction plus block fill, driven through a wait_access/main_mem_ready handshake.
- Stalls the core via memoryReady until the access completes.

Parameters:
- INDEX_BITS, 4, number of line-index bits; the cache holds 2^INDEX_BITS lines of 4 words (16 bytes) each.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- read  input  1  core load request
- write  input  1  core store request
- main_mem_ready  input  1  memory ready; high = idle/done, low = transaction in progress
- data_address  input  32  core byte address; [3:2] word offset, [3+INDEX_BITS:4] index, rest tag
- write_data  input  32  store data
- load_block  input  128  fill block from memory; word k at bits [32k+31:32k]
- load_address  output  32  block address to fill: {data_address[31:4],4'b0}
- read_data  output  32  load result
- evicted_block  output  128  victim block data, same word packing as load_block
- evicted_address  output  32  victim block address: {victim_tag,index,4'b0}
- evict  output  1  transaction includes a write-back of evicted_block
- load  output  1  transaction includes a fill read of load_address
- memoryReady  output  1  high = current request complete / no stall
- wait_access  output  1  start-transaction strobe to memory

Behaviour:
- Per-line storage: valid, dirty, tag (32-4-INDEX_BITS bits), 128-bit data.
- hit = valid[index] and tag[index] == address tag.
- State machine: IDLE, ISSUE, BUSY, FILL.
- IDLE, no request: memoryReady=1, read_data=0.
- IDLE, read hit: read_data = addressed word (combinational), memoryReady=1.
- IDLE, write hit: memoryReady=1; on the clock edge the addressed word takes write_data and dirty is set.
- read and write both high: handled as a write; read_data shows the pre-write word.
- IDLE, miss (read or write): memoryReady=0.
  - On the edge, register load_address, evicted_address, evicted_block (victim line data) and evict = valid&dirty of the victim.
  - Set load=1; go to ISSUE.
- ISSUE: wait_access=1 for exactly this one cycle; go to BUSY.
- BUSY: wait_access=0. Stay until main_mem_ready has been observed low and then high again; then go to FILL.
  - A ready-high seen before the low phase is ignored.
- load, evict, load_address, evicted_address, evicted_block are held constant from ISSUE through BUSY. Memory samples load/evict at its completion, not at start.
- FILL: on the edge, write load_block into the line; set tag, valid=1, dirty=0; clear load and evict; go to IDLE.
  - The still-held request then hits. A write merges into the line and sets dirty.
  - memoryReady is 0 in ISSUE, BUSY and FILL.
- Core contract: read, write, data_address and write_data stay stable until memoryReady=1.
- Clean victim or invalid line: evict=0; fill only.
- Dirty victim: evict=1 and load=1 in the same single transaction.
- Reset, including mid-transaction:
  - All valid and dirty bits cleared; state IDLE; no write-back of dirty data.
  - load=0, evict=0, wait_access=0, read_data=0, evicted_block=0, evicted_address=0, load_address=0.
  - memoryReady=1 while no request is present.
- Main-memory handshake:
  - Memory latches addresses and block on the wait_access cycle and drops main_mem_ready on the next edge.
  - It completes after a fixed latency (20 cycles in the system model), presents load_block, then raises main_mem_ready.
  - load_block is valid once main_mem_ready is high again.

Test Plan:
- Reset, then read 0x00000040 -> memoryReady=0; one-cycle wait_access with load=1, evict=0, load_address=0x00000040. After main_mem_ready rises, memoryReady=1 and read_data equals word 0 of load_block (memory preloaded 0x44443333_22221111_DDDDCCCC_BBBBAAAA -> 0xBBBBAAAA).
- Read 0x00000044 immediately after that fill -> hit; memoryReady=1 the same cycle; read_data=0xDDDDCCCC; wait_access stays 0.
- Write 0xCAFEF00D to 0x00000048 (hit) -> no stall; a following read of 0x48 returns 0xCAFEF00D; the line is now dirty.
- Read 0x00000440 (same index for INDEX_BITS=4, different tag) -> single transaction with evict=1, load=1, evicted_address=0x00000040, evicted_block word 2 = 0xCAFEF00D. A later read of 0x48 refills and returns 0xCAFEF00D from memory.
- Write miss to a clean invalid line, 0x00000080 data 0x12345678 -> fill with evict=0; memoryReady=1 only after the fill; a read of 0x80 then returns 0x12345678.
- Assert reset while in BUSY -> next cycle state IDLE, load/evict/wait_access=0; previously cached address 0x44 misses on the next read.
